// File: rtl/fpall_result_unpacker.sv
// fpall_result_unpacker
//   Takes one 32-bit FPALL result word and turns it into scalar result beats
//   on a valid/ready channel. A word holds either one FP32 value or two FP16
//   lanes. An FP32 word gives one beat. An FP16 word gives two beats, one per
//   lane.
//
//   Optional feature: define FPALL_LANE_MASK_EN to add in_lane_mask_i. FP16
//   lanes whose mask bit is clear are skipped, and the beat that remains is
//   marked last. A mask of 2'b00 consumes the word and emits nothing.
//
// Parameters
//   LANE_ORDER  0: emit u16[0] first, 1: emit u16[1] first
//   FP16_PAD    0: out_data[31:16] is zero on FP16 beats, 1: sign-extend bit 15
//
// Ports
//   clk, rst        clock, async active-high reset
//   in_valid_i      result word valid
//   in_ready_o      unpacker can take a word
//   in_fmt_i        0 = FP32, 1 = FP16
//   in_op_i         producing op, carried to every beat
//   in_data_i       packed result word
//   in_lane_mask_i  (FPALL_LANE_MASK_EN only) bit i set = lane u16[i] is real
//   out_valid_o     result beat valid
//   out_ready_i     downstream accepts the beat
//   out_data_o      FP32 value, or FP16 value in [15:0] with padding above it
//   out_fmt_o       format of the beat
//   out_op_o        op of the beat
//   out_lane_o      source lane (always 0 for FP32)
//   out_last_o      last beat of the current word
module fpall_result_unpacker #(
  parameter int LANE_ORDER = 0,
  parameter int FP16_PAD   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        in_fmt_i,
  input  logic [1:0]  in_op_i,
  input  logic [31:0] in_data_i,
`ifdef FPALL_LANE_MASK_EN
  input  logic [1:0]  in_lane_mask_i,
`endif
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        out_fmt_o,
  output logic [1:0]  out_op_o,
  output logic        out_lane_o,
  output logic        out_last_o
);

  typedef enum logic [1:0] {EMPTY, BEAT0, BEAT1} state_e;

  localparam logic FMT_FP32 = 1'b0;
  localparam logic FIRST    = (LANE_ORDER != 0);
  localparam logic SECOND   = ~FIRST;

  function automatic logic [31:0] pad16(input logic [15:0] h);
    return (FP16_PAD != 0) ? {{16{h[15]}}, h} : {16'h0000, h};
  endfunction

  function automatic logic [15:0] lane16(input logic [31:0] w, input logic l);
    return l ? w[31:16] : w[15:0];
  endfunction

  logic [1:0] lane_mask;
`ifdef FPALL_LANE_MASK_EN
  assign lane_mask = in_lane_mask_i;
`else
  assign lane_mask = 2'b11;
`endif

  state_e      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic        fmt_q, fmt_d;
  logic [1:0]  op_q, op_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic        lane_q, lane_d;
  logic        last_q, last_d;

  logic beat_fire, accept;

  assign beat_fire  = valid_q && out_ready_i;
  // When the last beat is leaving, a new word can load in the same cycle.
  // This is why back-to-back words have no gap.
  assign in_ready_o = (state_q == EMPTY) || (beat_fire && last_q);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    fmt_d   = fmt_q;
    op_d    = op_q;
    valid_d = valid_q;
    data_d  = data_q;
    lane_d  = lane_q;
    last_d  = last_q;

    if (beat_fire) begin
      if (last_q) begin
        state_d = EMPTY;
        valid_d = 1'b0;
      end else begin
        // A non-last first beat only happens when both lanes are present.
        // So the second beat always comes from the SECOND lane.
        state_d = BEAT1;
        data_d  = pad16(lane16(word_q, SECOND));
        lane_d  = SECOND;
        last_d  = 1'b1;
      end
    end

    // A new word takes priority over the retire step above.
    if (accept) begin
      word_d = in_data_i;
      fmt_d  = in_fmt_i;
      op_d   = in_op_i;
      if (in_fmt_i == FMT_FP32) begin
        state_d = BEAT0;
        valid_d = 1'b1;
        data_d  = in_data_i;
        lane_d  = 1'b0;
        last_d  = 1'b1;
      end else if (lane_mask[FIRST]) begin
        state_d = BEAT0;
        valid_d = 1'b1;
        data_d  = pad16(lane16(in_data_i, FIRST));
        lane_d  = FIRST;
        last_d  = !lane_mask[SECOND];
      end else if (lane_mask[SECOND]) begin
        state_d = BEAT0;
        valid_d = 1'b1;
        data_d  = pad16(lane16(in_data_i, SECOND));
        lane_d  = SECOND;
        last_d  = 1'b1;
      end else begin
        // Both lanes are masked off: drop the word and stay ready.
        state_d = EMPTY;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      word_q  <= '0;
      fmt_q   <= FMT_FP32;
      op_q    <= 2'b00;
      valid_q <= 1'b0;
      data_q  <= '0;
      lane_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      fmt_q   <= fmt_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      lane_q  <= lane_d;
      last_q  <= last_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_fmt_o   = fmt_q;
  assign out_op_o    = op_q;
  assign out_lane_o  = lane_q;
  assign out_last_o  = last_q;

endmodule

// File: tb/tb_fpall_result_unpacker.sv
module tb_fpall_result_unpacker;

  typedef struct packed {
    logic [31:0] d;
    logic        f;
    logic [1:0]  op;
    logic        lane;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_fmt = 1'b0;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_data = '0;
  logic [1:0]  mask = 2'b11;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_fmt;
  logic [1:0]  out_op;
  logic        out_lane;
  logic        out_last;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  beat_t exp_q[$];
  int    hs[$];

  fpall_result_unpacker #(.LANE_ORDER(0), .FP16_PAD(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_fmt_i(in_fmt), .in_op_i(in_op), .in_data_i(in_data),
`ifdef FPALL_LANE_MASK_EN
    .in_lane_mask_i(mask),
`endif
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_fmt_o(out_fmt), .out_op_o(out_op),
    .out_lane_o(out_lane), .out_last_o(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sx(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

  // Reference model of the beats a word should produce (LANE_ORDER=0, FP16_PAD=1).
  task automatic push_exp(input logic f, input logic [1:0] op, input logic [31:0] d);
    beat_t b;
    if (f == 1'b0) begin
      b = '{d: d, f: 1'b0, op: op, lane: 1'b0, last: 1'b1};
      exp_q.push_back(b);
    end else begin
      if (mask[0]) begin
        b = '{d: sx(d[15:0]), f: 1'b1, op: op, lane: 1'b0, last: !mask[1]};
        exp_q.push_back(b);
      end
      if (mask[1]) begin
        b = '{d: sx(d[31:16]), f: 1'b1, op: op, lane: 1'b1, last: 1'b1};
        exp_q.push_back(b);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      beat_t e;
      hs.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_beat", 64'(exp_q.size()), 64'd1);
      else begin
        e = exp_q.pop_front();
        chk("beat", 64'({out_data, out_fmt, out_op, out_lane, out_last}), 64'(e));
      end
    end
  end

  task automatic send(input logic f, input logic [1:0] op, input logic [31:0] d);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1; in_fmt = f; in_op = op; in_data = d;
    while (!ok && n < 20) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        push_exp(f, op, d);
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2;
    // Reset values, checked while reset is held.
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_fmt_op_lane_last", 64'({out_fmt, out_op, out_lane, out_last}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // FP32 single beat, one cycle latency, in_ready stays high.
    send(1'b0, 2'b01, 32'h3F80_0000);
    @(negedge clk);
    chk("fp32_valid_n1", 64'(out_valid), 64'd1);
    chk("fp32_in_ready", 64'(in_ready), 64'd1);
    chk("fp32_data_n1",  64'(out_data), 64'h3F80_0000);
    @(posedge clk); #1;
    drain();

    // FP16 word split into two sign-extended beats.
    send(1'b1, 2'b10, 32'hC000_3C00);
    drain();

    // Four FP32 words then one FP16 word: beats must arrive on consecutive cycles.
    hs.delete();
    send(1'b0, 2'b00, 32'h1111_1111);
    send(1'b0, 2'b01, 32'h2222_2222);
    send(1'b0, 2'b10, 32'h3333_3333);
    send(1'b0, 2'b11, 32'h4444_4444);
    send(1'b1, 2'b11, 32'h8001_7FFF);
    drain();
    chk("stream_beats", 64'(hs.size()), 64'd6);
    for (int i = 0; i + 1 < hs.size(); i++)
      chk($sformatf("stream_gap%0d", i), 64'(hs[i+1] - hs[i]), 64'd1);

    // Backpressure on the first FP16 beat: outputs frozen, no word accepted.
    out_ready = 1'b0;
    send(1'b1, 2'b01, 32'hBC00_4400);
    in_valid = 1'b1; in_fmt = 1'b0; in_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i),
          64'({out_valid, out_data, out_lane, out_last, in_ready}),
          64'({1'b1, 32'h0000_4400, 1'b0, 1'b0, 1'b0}));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Reset in the middle of an FP16 word.
    out_ready = 1'b0;
    send(1'b1, 2'b00, 32'h4000_3800);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    hs.delete();
    send(1'b0, 2'b10, 32'h4049_0FDB);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_beats", 64'(hs.size()), 64'd1);

`ifdef FPALL_LANE_MASK_EN
    mask = 2'b10;
    send(1'b1, 2'b01, 32'hC000_3C00);
    drain();
    mask = 2'b00;
    hs.delete();
    send(1'b1, 2'b01, 32'hC000_3C00);
    @(negedge clk);
    chk("mask00_ready", 64'(in_ready), 64'd1);
    chk("mask00_beats", 64'(hs.size()), 64'd0);
    mask = 2'b11;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
